// File: rtl/viterbi_pkg.sv
// Shared definitions for the viterbi_enc frame controller: state encoding,
// default code polynomials and the trellis tail-length helper.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam logic [2:0] POLY_A = 3'b111;
  localparam logic [2:0] POLY_B = 3'b101;

  function automatic int tail_len(input int size_polinom);
    return size_polinom - 1;
  endfunction

endpackage

// File: rtl/viterbi_enc_tail_cnt.sv
// Loadable down-counter that paces the zero tail: strobe while non-zero,
// done on the final count.
module viterbi_enc_tail_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             strobe,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign strobe = (cnt != '0);
  assign done   = (cnt == CNT_W'(1));

endmodule

// File: rtl/viterbi_enc_frame_ctrl.sv
// Frame sequencer in front of viterbi_enc: clear, data pass-through, zero tail,
// SOF/EOF markers and length limit. Optional counters: VITERBI_ENC_FRAME_CTRL_STATS_EN.
module viterbi_enc_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int p_size_polinom = 3,
  parameter int p_max_len      = 1024,
  parameter int p_len_w        = $clog2(p_max_len + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_enc_data,
  output logic               o_enc_valid,
  output logic               o_enc_reset,
  output logic               o_sof,
  output logic               o_eof,
  output logic               o_busy,
  output logic [p_len_w-1:0] o_frame_len,
  output logic               o_err_len
`ifdef VITERBI_ENC_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]        o_frame_cnt,
  output logic [7:0]         o_trunc_cnt
`endif
);

  localparam int TAIL_N = tail_len(p_size_polinom);
  localparam int TCNT_W = $clog2(p_size_polinom + 1);

  state_t             state, state_nxt;
  logic [p_len_w-1:0] count, count_inc;
  logic               first;
  logic               xfer, hit_max, data_end, trunc, final_strobe;
  logic               tail_load, tail_strobe, tail_done;

  viterbi_enc_tail_cnt #(.CNT_W(TCNT_W)) u_tail_cnt (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (tail_load),
    .load_val (TCNT_W'(TAIL_N)),
    .strobe   (tail_strobe),
    .done     (tail_done)
  );

  assign xfer      = (state == DATA) && i_valid;
  assign count_inc = count + 1'b1;
  assign hit_max   = xfer && (count_inc == p_len_w'(p_max_len));
  assign data_end  = xfer && (i_last || hit_max);
  assign trunc     = hit_max && !i_last;

  // With no tail the last data bit is itself the frame's final encoder strobe.
  assign final_strobe = (TAIL_N == 0) ? data_end : ((state == TAIL) && tail_done);

  assign o_enc_reset = i_reset || (state == CLR);
  assign o_busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    o_ready     = 1'b0;
    o_enc_valid = 1'b0;
    o_enc_data  = 1'b0;
    tail_load   = 1'b0;
    case (state)
      IDLE: if (i_valid) state_nxt = CLR;
      CLR:  state_nxt = DATA;
      DATA: begin
        o_ready     = 1'b1;
        o_enc_valid = i_valid;
        o_enc_data  = i_data;
        if (data_end) begin
          if (TAIL_N == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = TAIL;
            tail_load = 1'b1;
          end
        end
      end
      TAIL: begin
        o_enc_valid = tail_strobe;
        if (tail_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      count       <= '0;
      first       <= 1'b0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_frame_len <= '0;
      o_err_len   <= 1'b0;
    end else begin
      state <= state_nxt;
      o_sof <= xfer && first;
      o_eof <= final_strobe;
      if (state == CLR) begin
        count <= '0;
        first <= 1'b1;
      end else if (xfer) begin
        count <= count_inc;
        first <= 1'b0;
      end
      if (final_strobe) o_frame_len <= (TAIL_N == 0) ? count_inc : count;
      if (trunc) o_err_len <= 1'b1;
    end
  end

`ifdef VITERBI_ENC_FRAME_CTRL_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_frame_cnt <= '0;
      o_trunc_cnt <= '0;
    end else begin
      if (final_strobe) o_frame_cnt <= o_frame_cnt + 1'b1;
      if (trunc && (o_trunc_cnt != 8'hFF)) o_trunc_cnt <= o_trunc_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_enc_frame_ctrl.sv
// Directed + randomized bench for viterbi_enc_frame_ctrl with a rate-1/2 K=3
// encoder stand-in and a frame-level reference model.
module tb_viterbi_enc_frame_ctrl;
  import viterbi_pkg::*;

  localparam int MAXL   = 8;
  localparam int TAIL_N = 2;
  localparam int LEN_W  = $clog2(MAXL + 1);

  logic clk = 1'b0;
  logic rst, i_data, i_valid, i_last;
  logic o_ready, o_enc_data, o_enc_valid, o_enc_reset, o_sof, o_eof, o_busy, o_err_len;
  logic [LEN_W-1:0] o_frame_len;
`ifdef VITERBI_ENC_FRAME_CTRL_STATS_EN
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_trunc_cnt;
`endif

  always #5 clk = ~clk;

  viterbi_enc_frame_ctrl #(.p_size_polinom(3), .p_max_len(MAXL)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_enc_data  (o_enc_data),
    .o_enc_valid (o_enc_valid),
    .o_enc_reset (o_enc_reset),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_busy      (o_busy),
    .o_frame_len (o_frame_len),
    .o_err_len   (o_err_len)
`ifdef VITERBI_ENC_FRAME_CTRL_STATS_EN
    ,
    .o_frame_cnt (o_frame_cnt),
    .o_trunc_cnt (o_trunc_cnt)
`endif
  );

  // Encoder stand-in with registered output; symbol = {g(101), g(111)}.
  logic [1:0] sreg, sym;
  logic       sym_vld;
  always_ff @(posedge clk) begin
    if (o_enc_reset) begin
      sreg    <= '0;
      sym     <= '0;
      sym_vld <= 1'b0;
    end else begin
      sym_vld <= o_enc_valid;
      if (o_enc_valid) begin
        sym  <= {^({o_enc_data, sreg} & POLY_B), ^({o_enc_data, sreg} & POLY_A)};
        sreg <= {o_enc_data, sreg[1]};
      end
    end
  end

  logic [3:0] obs_q[$];
  int stray = 0, clr_cnt = 0;
  always @(negedge clk) begin
    if (sym_vld) obs_q.push_back({sym, o_sof, o_eof});
    if ((o_sof || o_eof) && !sym_vld) stray++;
    if (o_enc_reset && !rst) clr_cnt++;
  end

  int checks = 0, errors = 0;
  int obs_rd = 0, ready_bad = 0;
  logic [3:0] exp_q[$];
  logic frame_bits [0:63];
  int exp_len = 0, exp_frames = 0, exp_trunc = 0;
  bit exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ubit(input int j, input int k);
    if (j < 0 || j >= k) return 1'b0;
    return frame_bits[j];
  endfunction

  // Expected symbols of k data bits followed by tl zeros, straight from the
  // generator equations out0 = u[n]^u[n-1]^u[n-2], out1 = u[n]^u[n-2].
  task automatic model_push(input int k, input int tl, input bit eof_mark);
    int   tot;
    logic s0, s1;
    tot = k + tl;
    for (int j = 0; j < tot; j++) begin
      s0 = ubit(j, k) ^ ubit(j - 1, k) ^ ubit(j - 2, k);
      s1 = ubit(j, k) ^ ubit(j - 2, k);
      exp_q.push_back({s1, s0, (j == 0), (eof_mark && j == tot - 1)});
    end
  endtask

  task automatic model_frame(input int n, input bit with_last);
    bit tr;
    int k;
    tr = !(with_last && n <= MAXL);
    k  = tr ? MAXL : n;
    exp_len = k;
    if (tr) exp_err = 1'b1;
    exp_frames++;
    exp_trunc += int'(tr);
    model_push(k, TAIL_N, 1'b1);
  endtask

  task automatic xfer_bit(input logic b, input logic last, output bit ok);
    int w;
    w = 0;
    ok = 1'b0;
    i_valid = 1'b1;
    i_data  = b;
    i_last  = last;
    while (!ok && w < 20) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      else w++;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int n, input int gmin, input int gmax, input bit with_last);
    int acc, g;
    bit ok;
    acc = 0;
    for (int i = 0; i < n && acc < MAXL; i++) begin
      if (gmax > 0) begin
        g = $urandom_range(gmax, gmin);
        i_valid = 1'b0;
        i_last  = 1'b0;
        repeat (g) begin
          @(negedge clk);
          if (acc > 0 && !o_ready) ready_bad++;
          @(posedge clk); #1;
        end
      end
      xfer_bit(frame_bits[i], with_last && (i == n - 1), ok);
      check("handshake", 32'(ok), 32'd1);
      if (!ok) break;
      acc++;
    end
    if (acc == MAXL && !(with_last && n == MAXL)) begin
      i_data = frame_bits[MAXL];
      i_last = 1'b0;
      @(negedge clk);
      check("ready_drop", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 1'b0;
    model_frame(n, with_last);
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while (o_busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_idle", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_nsym"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_rd + i < obs_q.size()) check(tag, 32'(obs_q[obs_rd + i]), 32'(exp_q[i]));
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic set_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) frame_bits[i] = v[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t1_lit [0:5];
    int clr_base, n;
    bit ok, wl;
    t1_lit = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 64; i++) frame_bits[i] = 1'b0;
    rst = 1'b1; i_valid = 1'b0; i_data = 1'b0; i_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_enc_valid", 32'(o_enc_valid), 32'd0);
    check("rst_enc_data", 32'(o_enc_data), 32'd0);
    check("rst_enc_reset", 32'(o_enc_reset), 32'd1);
    check("rst_sof_eof", 32'({o_sof, o_eof}), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_frame_len", 32'(o_frame_len), 32'd0);
    check("rst_err_len", 32'(o_err_len), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_enc_reset", 32'(o_enc_reset), 32'd0);
    clr_base = clr_cnt;

    // Frame 1,0,1,1 contiguous
    set_bits(16'b1101, 4);
    send_frame(4, 0, 0, 1'b1);
    drain();
    for (int i = 0; i < 6; i++)
      if (obs_rd + i < obs_q.size()) check("t1_symbol", 32'(obs_q[obs_rd + i][3:2]), 32'(t1_lit[i]));
    compare_q("t1_stream");
    check("t1_frame_len", 32'(o_frame_len), 32'd4);
    check("t1_err_len", 32'(o_err_len), 32'd0);

    // Same frame with 1-3 cycle valid gaps
    send_frame(4, 1, 3, 1'b1);
    drain();
    compare_q("t2_stream");
    check("t2_ready_in_gaps", 32'(ready_bad), 32'd0);
    check("t2_frame_len", 32'(o_frame_len), 32'd4);

    // 10 bits without i_last against an 8-bit limit
    for (int i = 0; i < 10; i++) frame_bits[i] = 1'($urandom_range(1, 0));
    send_frame(10, 0, 0, 1'b0);
    drain();
    compare_q("t3_stream");
    check("t3_frame_len", 32'(o_frame_len), 32'(exp_len));
    check("t3_err_len", 32'(o_err_len), 32'(exp_err));
    check("t3_clears", 32'(clr_cnt - clr_base), 32'(exp_frames));

    // Reset during the 3rd data bit
    set_bits(16'b101, 3);
    xfer_bit(1'b1, 1'b0, ok);
    check("t4_hs1", 32'(ok), 32'd1);
    xfer_bit(1'b0, 1'b0, ok);
    check("t4_hs2", 32'(ok), 32'd1);
    i_data = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t4_busy", 32'(o_busy), 32'd0);
    check("t4_enc_reset", 32'(o_enc_reset), 32'd1);
    check("t4_ready", 32'(o_ready), 32'd0);
    check("t4_enc_valid", 32'(o_enc_valid), 32'd0);
    check("t4_markers", 32'({o_sof, o_eof}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    i_valid = 1'b0;
    model_push(2, 0, 1'b0);
    drain();
    compare_q("t4_partial");
    check("t4_err_cleared", 32'(o_err_len), 32'd0);
    check("t4_len_cleared", 32'(o_frame_len), 32'd0);
    exp_err = 1'b0; exp_frames = 0; exp_trunc = 0;
    clr_base = clr_cnt;
    frame_bits[0] = 1'b1;
    send_frame(1, 0, 0, 1'b1);
    drain();
    if (obs_rd < obs_q.size()) check("t4_clean_first", 32'(obs_q[obs_rd][3:2]), 32'd3);
    compare_q("t4_next");

    // Two back-to-back 1-bit frames
    frame_bits[0] = 1'b1;
    send_frame(1, 0, 0, 1'b1);
    send_frame(1, 0, 0, 1'b1);
    drain();
    compare_q("t5_stream");
    check("t5_clears", 32'(clr_cnt - clr_base), 32'(exp_frames));
    check("t5_frame_len", 32'(o_frame_len), 32'd1);

    // Randomized frames, led by one forced truncation
    for (int f = 0; f < 6; f++) begin
      n  = (f == 0) ? 9 : int'($urandom_range(10, 1));
      wl = (f == 0) ? 1'b0 : ((n <= MAXL) ? 1'b1 : 1'($urandom_range(1, 0)));
      for (int i = 0; i < n; i++) frame_bits[i] = 1'($urandom_range(1, 0));
      send_frame(n, 0, int'($urandom_range(3, 0)), wl);
      drain();
      compare_q("rnd_stream");
      check("rnd_frame_len", 32'(o_frame_len), 32'(exp_len));
      check("rnd_err_len", 32'(o_err_len), 32'(exp_err));
    end
    check("all_clears", 32'(clr_cnt - clr_base), 32'(exp_frames));
    check("ready_in_gaps", 32'(ready_bad), 32'd0);
    check("stray_markers", 32'(stray), 32'd0);
`ifdef VITERBI_ENC_FRAME_CTRL_STATS_EN
    check("frame_cnt", 32'(o_frame_cnt), 32'(exp_frames));
    check("trunc_cnt", 32'(o_trunc_cnt), 32'(exp_trunc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
